// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the read-side FIFO stages.
//   DSIZE_DEF    : default data word width
//   RD_BUF_DEPTH : output buffer entries (fixed at 3)
//   level_t      : buffered word count, 0..3
//   idx_inc      : ring index increment with 2 -> 0 wrap
package fifo_pkg;
  localparam int DSIZE_DEF    = 8;
  localparam int RD_BUF_DEPTH = 3;

  typedef logic [1:0] level_t;

  function automatic logic [1:0] idx_inc(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/rd_stream_stage_out_buf.sv
// rd_out_buf -- 3-entry output ring buffer for rd_stream_stage.
// Ports:
//   rclk, rrst_n : clock, async active-low reset
//   push, wdata  : write wdata at the tail this edge
//   m_ready      : downstream accept; head pops on m_valid && m_ready
//   m_valid      : buffer non-empty
//   m_data       : head entry (registered storage, no path from wdata)
//   m_level      : buffered word count
//   pop          : handshake strobe (m_valid && m_ready)
module rd_out_buf
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] wdata,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       m_level,
  output logic             pop
);
  logic [RD_BUF_DEPTH-1:0][DSIZE-1:0] mem;
  logic [1:0] head, tail;
  level_t     level;

  assign m_valid = (level != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[head];
  assign m_level = level;

  // Storage is cleared on reset so no pre-reset word can reappear on m_data.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      mem   <= '0;
      head  <= 2'd0;
      tail  <= 2'd0;
      level <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= idx_inc(tail);
      end
      if (pop) head <= idx_inc(head);
      // Simultaneous push and pop leaves the level unchanged.
      case ({push, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/rd_stream_stage.sv
// rd_stream_stage -- turns the synchronous-RAM read port of a FIFO into a
// valid/ready stream with a 3-entry skid buffer.
// Ports:
//   rclk, rrst_n : read clock, async active-low reset
//   rempty       : registered empty flag from the read-pointer stage
//   rinc         : pop request to the read-pointer stage
//   rdata        : RAM read data, valid the cycle after rinc
//   m_valid/m_ready/m_data : output stream
//   m_level      : buffered word count
//   rd_words     : (RD_STREAM_STATS_EN only) saturating handshake count
// Optional feature macro: RD_STREAM_STATS_EN
module rd_stream_stage
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       m_level
`ifdef RD_STREAM_STATS_EN
  ,
  output logic [15:0]      rd_words
`endif
);
  localparam int BUF_DEPTH = RD_BUF_DEPTH;

  logic       inflight;
  logic       pop;
  logic [2:0] occ;

  // Credit check counts the word still in the RAM pipe, so an arriving
  // word always has a free slot. m_ready is deliberately not a term here.
  assign occ  = {1'b0, m_level} + {2'b00, inflight};
  assign rinc = rrst_n && !rempty && (occ < 3'(BUF_DEPTH));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) inflight <= 1'b0;
    else         inflight <= rinc;
  end

  rd_out_buf #(.DSIZE(DSIZE)) u_buf (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .push    (inflight),
    .wdata   (rdata),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_level (m_level),
    .pop     (pop)
  );

`ifdef RD_STREAM_STATS_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)                      rd_words <= 16'd0;
    else if (pop && rd_words != 16'hFFFF) rd_words <= rd_words + 16'd1;
  end
`endif
endmodule

// File: doc/rd_stream_stage.md
RD_STREAM_STAGE -- requirements
Module: rd_stream_stage

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter BUF_DEPTH, fixed at 3, number of output buffer entries; not overridable.
REQ-003 SHALL have port rclk  input  1  read-domain clock; all state on rising edge.
REQ-004 SHALL have port rrst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rempty  input  1  registered empty flag from the read-pointer/empty stage.
REQ-006 SHALL have port rinc  output  1  pop request to the read-pointer/empty stage.
REQ-007 SHALL have port rdata  input  DSIZE  synchronous-RAM read data, valid the cycle after rinc.
REQ-008 SHALL have port m_valid  output  1  output word valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts word.
REQ-010 SHALL have port m_data  output  DSIZE  output word.
REQ-011 SHALL have port m_level  output  2  buffered word count, 0..3.

Function
REQ-012 SHALL track inflight (1 bit): set on a cycle with rinc=1, cleared otherwise.
REQ-013 SHALL drive rinc = !rempty && (m_level + inflight < 3), from registered state only; no m_ready-to-rinc path.
REQ-014 SHALL never assert rinc while rempty=1.
REQ-015 SHALL write rdata into the buffer tail at the clock edge ending each cycle with inflight=1.
REQ-016 SHALL assert m_valid iff m_level != 0; m_data = buffer head entry, registered (no path from rdata).
REQ-017 SHALL pop the head on m_valid && m_ready; m_data/m_valid SHALL hold stable while m_valid && !m_ready.
REQ-018 SHALL give first-word latency of 2 cycles: rinc at cycle t, rdata at t+1, m_valid at t+2.
REQ-019 SHALL sustain 1 word/cycle when rempty=0 and m_ready=1 continuously, after the initial latency.
REQ-020 SHALL handle push and pop in the same cycle: m_level unchanged, order preserved.
REQ-021 SHALL wrap head/tail indices 2->0; words SHALL exit in rdata arrival order.
REQ-022 SHALL never overflow: inflight=1 implies m_level <= 2 at arrival.

Reset
REQ-023 SHALL force m_level=0, inflight=0, m_valid=0, head=tail=0 immediately on rrst_n low.
REQ-024 SHALL hold rinc=0 while rrst_n=0, regardless of rempty.
REQ-025 SHALL reset m_data to 0.
REQ-026 SHALL discard buffered and in-flight words on reset mid-operation; a word arriving the cycle after release SHALL be ignored.

Configuration
REQ-027 SHALL honour macro RD_STREAM_STATS_EN.
REQ-028 With RD_STREAM_STATS_EN defined, SHALL add output rd_words (16 bits): saturating count of m_valid && m_ready handshakes, reset to 0, sticking at 16'hFFFF.
REQ-029 Without RD_STREAM_STATS_EN, SHALL have no rd_words port and no counter logic; other behaviour SHALL be identical.

Structure
REQ-030 SHALL take DSIZE default and the level type (2-bit unsigned) from shared package fifo_pkg.
REQ-031 SHALL place buffer storage and head/tail/level logic in one sub-module, rd_out_buf; rinc/inflight control SHALL stay in rd_stream_stage.

Verification
REQ-032 Reset with rempty=0: rinc=0, m_valid=0, m_level=0 during reset; rinc=1 first cycle after release.
REQ-033 Single word 8'hA5, m_ready=1: rinc cycle t, m_valid=1 and m_data=8'hA5 at t+2 for one cycle, m_level returns to 0.
REQ-034 Ten words 0..9 back-to-back, m_ready=1: m_valid high 10 consecutive cycles, data 0..9 in order, no bubbles.
REQ-035 m_ready=0 with rempty=0: m_level reaches 3, rinc drops, data held; m_ready=1 then drains in order with no loss.
REQ-036 Reset asserted with m_level=2 and inflight=1: outputs clear at once; after release the old words never appear on m_data.
REQ-037 With RD_STREAM_STATS_EN: 70000 handshakes give rd_words=16'hFFFF; a reset gives 0.
